code_decoder: RTL
=================

# code_decoder

Pipelined inverse of the ALU code-conversion unit (opcode 1110). It accepts an encoded byte plus a 2-bit mode and returns the 4-bit binary value that produced it. Invalid codes are flagged and counted. It sits downstream of the ALU result path and talks to both neighbours through valid/ready handshakes. Throughput is one code per cycle and latency is two cycles.

## Interface
Parameters:
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- init_in  in  1  reset, synchronous, active-low; the block is held in reset while init_in is 0.
- in_valid  in  1  upstream presents code_in/mode_in.
- in_ready  out  1  block can accept; a transfer occurs when in_valid and in_ready are both 1 at a rising edge.
- code_in  in  8  encoded value.
- mode_in  in  2  code type: 00 BCD, 01 Gray, 10 XS-3, 11 XS-5.
- out_valid  out  1  bin_out and err_out are valid.
- out_ready  in  1  downstream accepts.
- bin_out  out  4  decoded binary value.
- err_out  out  1  code was invalid for the selected mode.
- clr_cnt_in  in  1  synchronous clear of err_cnt_out.
- err_cnt_out  out  CNT_W  count of invalid results delivered downstream.

## Operation
Pipeline structure:
- Stage 1 (S1) registers code_in and mode_in on an input transfer.
- Stage 2 (S2) registers the decode of S1, which is bin_out and err_out.
- Each stage has a valid bit.

Flow control:
- S2 advances when S2 is empty or out_ready is 1.
- S1 advances into S2 when S2 advances.
- in_ready = !S1_valid || S2 advances. This is combinational from out_ready and gives no bubble at full rate.
- Data is never dropped or duplicated.
- While out_valid=1 and out_ready=0, bin_out and err_out must stay stable.

Decode rules (c = code_in, n = c[3:0]):
- BCD (00):
  - c[7:4]=0 and n≤9 → n.
  - c[7:4]=1 and n≤5 → 10+n.
  - Anything else → error.
- Gray (01):
  - c[7:4] must be 0, otherwise error.
  - b3=n3, b2=b3^n2, b1=b2^n1, b0=b1^n0.
- XS-3 (10):
  - 3≤c≤12 → c−3.
  - 67≤c≤72 → c−57.
  - Anything else → error.
- XS-5 (11):
  - 5≤c≤14 → c−5.
  - 101≤c≤106 → c−91.
  - Anything else → error.
- On error, bin_out=0 and err_out=1.
- All arithmetic is unsigned 8-bit; the result is truncated to 4 bits only after the range check.

Error counter:
- Increments by 1 on each output transfer (out_valid & out_ready) with err_out=1.
- Saturates at 2^CNT_W−1; it never wraps.
- When clr_cnt_in=1, the next value is 0. Clear wins over a simultaneous increment.

## Timing
- Reset values (init_in=0 at an edge): S1_valid=0, S2_valid=0, out_valid=0, bin_out=0, err_out=0, err_cnt_out=0.
- in_ready=0 while init_in=0 and 1 in the first cycle after release.
- Reset mid-operation discards all in-flight codes; no partial output appears after release.
- Latency: a code accepted at edge k gives out_valid=1 after edge k+1, provided out_ready was 1 or S2 was empty.
- Back-to-back input with out_ready held at 1 gives one output per cycle, in order.
- With out_ready=0 for ≥2 cycles, the pipeline fills (2 entries) and in_ready drops to 0 one cycle after S1 fills.
- When out_ready returns to 1, in_ready=1 in the same cycle.
- err_cnt_out updates on the edge of the erroneous output transfer and is visible the next cycle.

## Test plan
- Reset then valid codes, out_ready=1:
  - mode 00 with 0x07, 0x15, 0x10 → 7, 15, 10, err=0.
  - Each result arrives 2 cycles after acceptance, one per cycle.
- All four modes, all 16 values:
  - Encode v=0..15 with the ALU rules (e.g. XS-3 of 12 = 69, XS-5 of 15 = 106, Gray of 9 = 0x0D).
  - Decode → v, err=0.
- Invalid codes:
  - BCD 0x0A and 0x16, Gray 0x1F, XS-3 2 and 13, XS-5 4 and 107.
  - Each → err_out=1, bin_out=0; err_cnt_out ends at 7.
- Backpressure:
  - Hold out_ready=0 for 5 cycles while in_valid=1.
  - Exactly 2 codes accepted, then in_ready=0 and outputs stable.
  - Release out_ready → codes emerge in order, none lost.
- Counter edges:
  - Force 260 errors with CNT_W=8 → err_cnt_out=255.
  - clr_cnt_in asserted in the same cycle as an error transfer → 0.
- Reset mid-stream:
  - Drive init_in=0 with 2 codes in flight → out_valid=0 next cycle.
  - After release, no stale output and in_ready=1.

Source files
------------

// File: rtl/code_decoder.sv
// code_decoder: two-stage valid/ready pipeline that turns BCD / Gray / XS-3 / XS-5
// bytes back into 4-bit binary. It flags invalid codes and counts them with a
// saturating counter.
module code_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             init_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       code_in,
    input  logic [1:0]       mode_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       bin_out,
    output logic             err_out,
    input  logic             clr_cnt_in,
    output logic [CNT_W-1:0] err_cnt_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Decode one code for the selected mode. Result is {err, bin}.
    // The range check uses the full 8 bits; truncation to 4 bits happens last.
    function automatic logic [4:0] decode(input logic [7:0] c, input logic [1:0] m);
        logic [3:0] n;
        logic [3:0] g;
        logic [7:0] d;
        logic       ok;
        n  = c[3:0];
        g  = '0;
        d  = '0;
        ok = 1'b0;
        case (m)
            2'b00: begin
                if (c[7:4] == 4'd0 && n <= 4'd9) begin
                    ok = 1'b1;
                    d  = {4'd0, n};
                end else if (c[7:4] == 4'd1 && n <= 4'd5) begin
                    ok = 1'b1;
                    d  = {4'd0, n} + 8'd10;
                end
            end
            2'b01: begin
                if (c[7:4] == 4'd0) begin
                    g[3] = n[3];
                    g[2] = g[3] ^ n[2];
                    g[1] = g[2] ^ n[1];
                    g[0] = g[1] ^ n[0];
                    ok   = 1'b1;
                    d    = {4'd0, g};
                end
            end
            2'b10: begin
                if (c >= 8'd3 && c <= 8'd12) begin
                    ok = 1'b1;
                    d  = c - 8'd3;
                end else if (c >= 8'd67 && c <= 8'd72) begin
                    ok = 1'b1;
                    d  = c - 8'd57;
                end
            end
            default: begin
                if (c >= 8'd5 && c <= 8'd14) begin
                    ok = 1'b1;
                    d  = c - 8'd5;
                end else if (c >= 8'd101 && c <= 8'd106) begin
                    ok = 1'b1;
                    d  = c - 8'd91;
                end
            end
        endcase
        return ok ? {1'b0, d[3:0]} : 5'b1_0000;
    endfunction

    logic             vld_p1;
    logic             vld_p2;
    logic [7:0]       code_p1;
    logic [1:0]       mode_p1;
    logic [3:0]       bin_p2;
    logic             err_p2;
    logic [CNT_W-1:0] cnt;
    logic             s2_adv;
    logic             in_xfer;
    logic             out_xfer;
    logic [4:0]       dec_p1;

    // Handshake: S2 moves when empty or drained, and S1 follows S2.
    always_comb begin
        s2_adv   = !vld_p2 || out_ready;
        in_ready = init_in && (!vld_p1 || s2_adv);
        in_xfer  = in_valid && in_ready;
        out_xfer = vld_p2 && out_ready;
        dec_p1   = decode(code_p1, mode_p1);
    end

    // Stage 1 data capture: only loaded on an accepted transfer, no reset needed.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            code_p1 <= code_in;
            mode_p1 <= mode_in;
        end
    end

    // Valid bits, stage 2 result and error counter; reset discards in-flight codes.
    always_ff @(posedge clk) begin
        if (!init_in) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            bin_p2 <= '0;
            err_p2 <= 1'b0;
            cnt    <= '0;
        end else begin
            // ---- S1 boundary ----
            if (in_ready) begin
                vld_p1 <= in_valid;
            end
            // ---- S2 boundary ----
            if (s2_adv) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    err_p2 <= dec_p1[4];
                    bin_p2 <= dec_p1[3:0];
                end
            end
            if (clr_cnt_in) begin
                cnt <= '0;
            end else if (out_xfer && err_p2 && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign out_valid   = vld_p2;
    assign bin_out     = bin_p2;
    assign err_out     = err_p2;
    assign err_cnt_out = cnt;

endmodule
